inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Fetch stage directly downstream of the PC register: takes each PC the PC register
//  produces and fetches its instruction over a req/gnt/rvalid memory port.
//  Returns {pc, inst} pairs through a DEPTH-entry FIFO to IF/ID using valid/ready.
//  Drives pc_stall back to the PC register.
//  Keeps one memory transaction outstanding at a time. Supports flush on redirect.
// PARAMETERS
//  ADDR_W  32  PC / memory address width
//  DATA_W  32  instruction width
//  DEPTH   2   output FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-low (asserted when 0)
//  pc          in   ADDR_W  current PC from PC register
//  pc_ce       in   1       pc valid (PC register enable)
//  pc_stall    out  1       1 = PC register must hold pc this cycle
//  flush       in   1       discard all buffered/in-flight fetches
//  mem_req     out  1       memory request, held until mem_gnt
//  mem_addr    out  ADDR_W  request address, stable while mem_req=1
//  mem_gnt     in   1       request accepted
//  mem_rvalid  in   1       read data valid (>=1 cycle after gnt)
//  mem_rdata   in   DATA_W  read data
//  inst_valid  out  1       FIFO head valid
//  inst_pc     out  ADDR_W  FIFO head pc
//  inst        out  DATA_W  FIFO head instruction
//  id_ready    in   1       IF/ID consumes head when inst_valid & id_ready
// BEHAVIOUR
//  Reset (rst=0, async):
//   state=IDLE, FIFO empty, count=0, drop=0.
//   Outputs: mem_req=0, mem_addr=0, inst_valid=0, inst_pc=0, inst=0, pc_stall=1.
//  Definitions:
//   space = (count + (state!=IDLE)) < DEPTH; the in-flight fetch reserves a slot.
//  FSM:
//   IDLE: pc_stall = !(pc_ce & space & !flush).
//    If pc_ce & space & !flush: latch mem_addr<=pc, go REQ.
//    This is the pc accept; the PC register advances the same edge.
//   REQ: mem_req=1, pc_stall=1; on mem_gnt go WAIT.
//    Request is never retracted, even on flush.
//   WAIT: pc_stall=1; on mem_rvalid go IDLE.
//    Push {mem_addr, mem_rdata} unless drop=1 or flush=1 that cycle.
//    Clear drop.
//  Latency (gnt same cycle as req, rvalid one cycle after gnt):
//   pc accepted edge N -> mem_req cycle N+1 -> rvalid N+2 -> inst_valid cycle N+3.
//   Sustained rate: 1 instr per 3 cycles.
//  FIFO:
//   Head visible combinationally (inst_valid = count!=0).
//   Pop on inst_valid & id_ready. Push & pop in the same cycle allowed; count unchanged.
//   Pointers wrap modulo DEPTH.
//   inst_pc/inst hold last value when empty; no check on content.
//  Flush (level, sampled each edge):
//   FIFO emptied (count=0) at the edge; a pop that cycle is ignored.
//   If state is REQ or WAIT: drop<=1.
//    The eventual response is discarded, then state returns to IDLE.
//   In IDLE: no accept that cycle.
//   Flush coincident with rvalid: data discarded, state->IDLE, drop stays 0.
//  Full: while !space, pc_stall=1 and no request is issued.
//  Reset mid-transaction clears everything immediately; mem_req drops to 0.
//   Memory side must tolerate an abandoned request.
// TESTING
//  1. Reset then pc_ce=1, pc=0x00, mem always gnt, rvalid 1 cycle later, id_ready=1
//     -> inst_valid first at cycle 3 with pc 0x00; pcs 0x00, 0x04, 0x08 appear in order.
//  2. id_ready=0, DEPTH=2 -> exactly 2 entries (0x00, 0x04) buffered; pc_stall stays 1;
//     mem_req stays 0. Set id_ready=1 -> fetch resumes at pc 0x08.
//  3. mem_gnt held 0 for 5 cycles -> mem_req and mem_addr=0x10 stable all 5 cycles;
//     pc_stall=1 throughout.
//  4. flush in WAIT -> FIFO empties next edge. Returning rdata 0xDEADBEEF is not
//     pushed; next accepted pc fetched normally.
//  5. flush same cycle as rvalid and id_ready pop -> count=0, no push, state IDLE.
//  6. rst=0 asynchronously while mem_req=1 -> mem_req, inst_valid drop to 0 before the
//     next clk edge; pc_stall=1.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction memory port between the fetch stage (master) and instruction memory (slave).
// The request is held until it is granted; read data returns later on rvalid.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: turns accepted PCs into single-outstanding memory reads and queues
// {pc, inst} pairs in a small FIFO towards IF/ID, with flush on redirect.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_ce,
  output logic              pc_stall,
  input  logic              flush,
  inst_fetch_if.master      mem,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst,
  input  logic              id_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic              drop_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] pc_fifo   [DEPTH];
  logic [DATA_W-1:0] inst_fifo [DEPTH];

  logic busy, space, accept, push, pop;

  // The in-flight fetch reserves a FIFO slot so its response can always be stored.
  assign busy  = (state_reg != IDLE);
  assign space = (count_reg + CNT_W'(busy)) < CNT_W'(DEPTH);

  assign inst_valid   = (count_reg != '0);
  assign inst_pc      = pc_fifo[rd_ptr_reg];
  assign inst         = inst_fifo[rd_ptr_reg];
  assign pop          = inst_valid && id_ready && !flush;
  assign mem.mem_addr = addr_reg;

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    push        = 1'b0;
    pc_stall    = 1'b1;
    mem.mem_req = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rst && pc_ce && space && !flush) begin
          accept     = 1'b1;
          pc_stall   = 1'b0;
          state_next = REQ;
        end
      end
      REQ: begin
        mem.mem_req = 1'b1;
        if (mem.mem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          state_next = IDLE;
          push       = !drop_reg && !flush;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) addr_reg <= pc;
      // A response arriving always clears drop, so a flush on that same cycle leaves it at 0.
      if (state_reg == WAIT && mem.mem_rvalid) drop_reg <= 1'b0;
      else if (flush && busy)                  drop_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_fifo[i]   <= '0;
        inst_fifo[i] <= '0;
      end
    end else if (flush) begin
      count_reg  <= '0;
      rd_ptr_reg <= wr_ptr_reg;
    end else begin
      if (push) begin
        pc_fifo[wr_ptr_reg]   <= addr_reg;
        inst_fifo[wr_ptr_reg] <= mem.mem_rdata;
        wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: accepted PCs are queued as expectations and
// compared against each {inst_pc, inst} consumed by IF/ID.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        pc_ce = 1'b1;
  logic        pc_stall;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        id_ready = 1'b1;

  logic        gnt_en   = 1'b1;
  int          rv_delay = 1;
  logic [31:0] dead_addr = 32'hFFFF_FFFF;
  logic [31:0] pc_start  = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic        accept_seen = 1'b0;
  logic        gnt_now = 1'b0;
  logic [31:0] addr_now = 32'h0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  inst_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_ce      (pc_ce),
    .pc_stall   (pc_stall),
    .flush      (flush),
    .mem        (mif.master),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .inst       (inst),
    .id_ready   (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory model: grant follows gnt_en, response rv_delay cycles after grant.
  assign mif.mem_gnt = gnt_en;

  always @(negedge clk) begin
    gnt_now  = rst && mif.mem_req && mif.mem_gnt;
    addr_now = mif.mem_addr;
  end

  always @(posedge clk) begin
    #1;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = 32'h0;
    if (!rst) begin
      pend = 1'b0;
    end else begin
      if (gnt_now) begin
        pend  = 1'b1;
        cnt   = rv_delay;
        paddr = addr_now;
      end
      if (pend) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = (paddr == dead_addr) ? 32'hDEAD_BEEF : data_of(paddr);
          pend = 1'b0;
        end
      end
    end
  end

  // PC register model: advances on every accepted pc.
  always @(posedge clk) begin
    #1;
    if (!rst)             pc = pc_start;
    else if (accept_seen) pc = pc + 32'd4;
  end

  // Scoreboard: push on accept, pop-and-compare on consume, clear on flush/reset.
  always @(negedge clk) begin
    logic [31:0] e;
    accept_seen = rst && pc_ce && !pc_stall;
    if (!rst || flush) begin
      exp_q.delete();
    end else begin
      if (inst_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", inst_pc, e);
          check("sb_inst", inst, data_of(e));
          $display("pop pc=%08h inst=%08h", inst_pc, inst);
        end
      end
      if (accept_seen) exp_q.push_back(pc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst      = 1'b0;
    pc_start = start;
    pc_ce    = 1'b1;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      tick();
      if (inst_valid) break;
    end
    if (k == 40) check(tag, 32'(inst_valid), 32'h1);
  endtask

  task automatic wait_req(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      tick();
      if (mif.mem_req) break;
    end
    if (k == 40) check(tag, 32'(mif.mem_req), 32'h1);
  endtask

  task automatic drain(input string tag);
    drive();
    pc_ce    = 1'b0;
    gnt_en   = 1'b1;
    id_ready = 1'b1;
    repeat (15) tick();
    check({tag, "_left"}, 32'(exp_q.size()), 32'h0);
    check({tag, "_valid"}, 32'(inst_valid), 32'h0);
  endtask

  initial begin
    int k;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = 32'h0;
    pc             = 32'h0;

    // Reset state, with pc_ce high the whole time
    tick();
    check("rst_mem_req", 32'(mif.mem_req), 32'h0);
    check("rst_mem_addr", mif.mem_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc_stall", 32'(pc_stall), 32'h1);

    // 1: first instruction latency and in-order stream
    id_ready = 1'b1;
    rv_delay = 1;
    do_reset(32'h0);
    for (k = 0; k < 20; k++) begin
      tick();
      if (inst_valid) break;
    end
    check("t1_first_cycle", 32'(k), 32'd3);
    check("t1_first_pc", inst_pc, 32'h0);
    repeat (8) tick();
    drain("t1_drain");

    // 2: consumer stalled, FIFO fills to DEPTH, then resumes at 0x08
    id_ready = 1'b0;
    do_reset(32'h0);
    repeat (15) tick();
    check("t2_buffered", 32'(exp_q.size()), 32'd2);
    check("t2_head_pc", inst_pc, 32'h0);
    check("t2_pc_stall", 32'(pc_stall), 32'h1);
    check("t2_mem_req", 32'(mif.mem_req), 32'h0);
    drive();
    id_ready = 1'b1;
    wait_req("t2_resume_timeout");
    check("t2_resume_addr", mif.mem_addr, 32'h8);
    drain("t2_drain");

    // 3: grant withheld, request and address held stable
    gnt_en = 1'b0;
    id_ready = 1'b1;
    do_reset(32'h10);
    wait_req("t3_req_timeout");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_mem_req", 32'(mif.mem_req), 32'h1);
      check("t3_mem_addr", mif.mem_addr, 32'h10);
      check("t3_pc_stall", 32'(pc_stall), 32'h1);
    end
    drive();
    gnt_en = 1'b1;
    drain("t3_drain");

    // 4: flush while waiting for data; the late 0xDEADBEEF response is dropped
    id_ready  = 1'b0;
    rv_delay  = 3;
    dead_addr = 32'h4;
    do_reset(32'h0);
    wait_valid("t4_valid_timeout");
    wait_req("t4_req_timeout");
    drive();
    flush = 1'b1;
    drive();
    flush = 1'b0;
    tick();
    check("t4_flush_empty", 32'(inst_valid), 32'h0);
    wait_valid("t4_refill_timeout");
    check("t4_head_pc", inst_pc, 32'h8);
    check("t4_head_inst", inst, data_of(32'h8));
    drain("t4_drain");
    dead_addr = 32'hFFFF_FFFF;

    // 5: flush coincident with rvalid and a pop
    id_ready = 1'b0;
    rv_delay = 1;
    do_reset(32'h0);
    wait_valid("t5_valid_timeout");
    for (k = 0; k < 20; k++) begin
      drive();
      if (mif.mem_rvalid) begin
        flush    = 1'b1;
        id_ready = 1'b1;
        break;
      end
    end
    if (k == 20) check("t5_rvalid_timeout", 32'(mif.mem_rvalid), 32'h1);
    drive();
    flush = 1'b0;
    tick();
    check("t5_count_zero", 32'(inst_valid), 32'h0);
    check("t5_idle_accept", 32'(pc_stall), 32'h0);
    check("t5_next_pc", pc, 32'h8);
    drain("t5_drain");

    // 6: asynchronous reset while a request is outstanding
    id_ready = 1'b0;
    gnt_en   = 1'b1;
    do_reset(32'h0);
    wait_valid("t6_valid_timeout");
    drive();
    gnt_en = 1'b0;
    wait_req("t6_req_timeout");
    check("t6_pre_req", 32'(mif.mem_req), 32'h1);
    check("t6_pre_valid", 32'(inst_valid), 32'h1);
    rst = 1'b0;
    #1;
    check("t6_async_req", 32'(mif.mem_req), 32'h0);
    check("t6_async_valid", 32'(inst_valid), 32'h0);
    check("t6_async_stall", 32'(pc_stall), 32'h1);
    gnt_en   = 1'b1;
    id_ready = 1'b1;
    do_reset(32'h40);
    repeat (8) tick();
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
